// File: rtl/bus_receiver_if.sv
// Bus receiver ports: tri-state bus capture side, FIFO read handshake, status and sticky error flags.
// The slave modport is the receiver; the master modport is the bus/controller/consumer environment.
interface bus_receiver_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    tri   [WIDTH-1:0] bus_data;
    logic             bus_en;
    logic             load;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             err_nodrv;
    logic             err_ovf;
    logic             err_x;

    modport master (
        output bus_data,
        output bus_en,
        output load,
        output clr_err,
        output rd_ready,
        input  rd_data,
        input  rd_valid,
        input  count,
        input  full,
        input  err_nodrv,
        input  err_ovf,
        input  err_x
    );

    modport slave (
        input  bus_data,
        input  bus_en,
        input  load,
        input  clr_err,
        input  rd_ready,
        output rd_data,
        output rd_valid,
        output count,
        output full,
        output err_nodrv,
        output err_ovf,
        output err_x
    );
endinterface

// File: rtl/bus_receiver.sv
// Samples the shared tri-state bus on a qualified load strobe into a small FIFO read via valid/ready.
// Optional X/Z capture check on the bus word is enabled by defining BUS_XCHK_EN.
module bus_receiver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    bus_receiver_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             errNodrv_q, errNodrv_d;
    logic             errOvf_q, errOvf_d;

    logic empty;
    logic full;
    logic capture;
    logic rd;
    logic wr;

    // A full FIFO still accepts a write when the same edge pops the head.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign capture = bus.load && bus.bus_en;
    assign rd      = !empty && bus.rd_ready;
    assign wr      = capture && (!full || rd);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wr) wrPtr_d = wrPtr_q + PW'(1);
        if (rd) rdPtr_d = rdPtr_q + PW'(1);
        case ({wr, rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set condition overrides a simultaneous clear.
        errNodrv_d = (errNodrv_q && !bus.clr_err) || (bus.load && !bus.bus_en);
        errOvf_d   = (errOvf_q && !bus.clr_err) || (capture && full && !rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            errNodrv_q <= 1'b0;
            errOvf_q   <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            errNodrv_q <= errNodrv_d;
            errOvf_q   <= errOvf_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wrPtr_q] <= bus.bus_data;
    end

`ifdef BUS_XCHK_EN
    logic errX_q, errX_d;

    always_comb begin
        errX_d = (errX_q && !bus.clr_err) || (wr && ((^bus.bus_data) === 1'bx));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) errX_q <= 1'b0;
        else     errX_q <= errX_d;
    end

    assign bus.err_x = errX_q;
`else
    assign bus.err_x = 1'b0;
`endif

    assign bus.rd_data   = mem_q[rdPtr_q];
    assign bus.rd_valid  = !empty;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.err_nodrv = errNodrv_q;
    assign bus.err_ovf   = errOvf_q;
endmodule

// File: tb/tb_bus_receiver.sv
// Self-checking bench for bus_receiver: directed vector table, reset corner sequence,
// then randomized traffic compared against a queue-based reference model.
module tb_bus_receiver;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic       load;
        logic       busEn;
        logic [7:0] data;
        logic       rdReady;
        logic       clrErr;
        logic       expValid;
        logic       chkData;
        logic [7:0] expData;
        logic [2:0] expCount;
        logic       expFull;
        logic       expNodrv;
        logic       expOvf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] tbBusData;
    int         testsRun;
    int         testsFailed;

    bus_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) busIf ();

    assign busIf.bus_data = tbBusData;

    bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ld, input logic en, input logic [7:0] d,
                                 input logic rdy, input logic clr);
        busIf.load     = ld;
        busIf.bus_en   = en;
        tbBusData      = d;
        busIf.rd_ready = rdy;
        busIf.clr_err  = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic ld, input logic en, input logic [7:0] d,
                                   input logic rdy, input logic clr, input logic v,
                                   input logic cd, input logic [7:0] ed, input logic [2:0] c,
                                   input logic f, input logic nd, input logic ov);
        vec_t r;
        r.load = ld;  r.busEn = en;  r.data = d;  r.rdReady = rdy;  r.clrErr = clr;
        r.expValid = v;  r.chkData = cd;  r.expData = ed;  r.expCount = c;
        r.expFull = f;  r.expNodrv = nd;  r.expOvf = ov;
        return r;
    endfunction

    // One clock per vector: drive, let the edge pass, sample 1 time unit later.
    task automatic runVector(input int idx, input vec_t v);
        applyStimulus(v.load, v.busEn, v.data, v.rdReady, v.clrErr);
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d rd_valid", idx), 32'(busIf.rd_valid), 32'(v.expValid));
        if (v.chkData)
            checkOutput($sformatf("vec%0d rd_data", idx), 32'(busIf.rd_data), 32'(v.expData));
        checkOutput($sformatf("vec%0d count", idx), 32'(busIf.count), 32'(v.expCount));
        checkOutput($sformatf("vec%0d full", idx), 32'(busIf.full), 32'(v.expFull));
        checkOutput($sformatf("vec%0d err_nodrv", idx), 32'(busIf.err_nodrv), 32'(v.expNodrv));
        checkOutput($sformatf("vec%0d err_ovf", idx), 32'(busIf.err_ovf), 32'(v.expOvf));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[$];
    int   q[$];
    logic mNodrv;
    logic mOvf;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rd_valid", 32'(busIf.rd_valid), 32'd0);
        checkOutput("reset count", 32'(busIf.count), 32'd0);
        checkOutput("reset full", 32'(busIf.full), 32'd0);
        checkOutput("reset err_nodrv", 32'(busIf.err_nodrv), 32'd0);
        checkOutput("reset err_ovf", 32'(busIf.err_ovf), 32'd0);
        checkOutput("reset err_x", 32'(busIf.err_x), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //                ld  en  data   rdy clr  valid chk  data  cnt full nodrv ovf
        vecs.push_back(mkVec(0, 0, 8'd0,   0, 0,  0,  0, 8'd0,   3'd0, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd123, 0, 0,  1,  1, 8'd123, 3'd1, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'd0,   1, 0,  0,  0, 8'd0,   3'd0, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd10,  0, 0,  1,  1, 8'd10,  3'd1, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd11,  0, 0,  1,  1, 8'd10,  3'd2, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd12,  0, 0,  1,  1, 8'd10,  3'd3, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd13,  0, 0,  1,  1, 8'd10,  3'd4, 1, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd14,  0, 0,  1,  1, 8'd10,  3'd4, 1, 0, 1));
        vecs.push_back(mkVec(0, 0, 8'd0,   0, 1,  1,  1, 8'd10,  3'd4, 1, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'd99,  1, 0,  1,  1, 8'd11,  3'd4, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   1, 0,  1,  1, 8'd12,  3'd3, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   1, 0,  1,  1, 8'd13,  3'd2, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   1, 0,  1,  1, 8'd99,  3'd1, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   1, 0,  0,  0, 8'd0,   3'd0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   1, 0,  0,  0, 8'd0,   3'd0, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'd55,  0, 0,  0,  0, 8'd0,   3'd0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   0, 1,  0,  0, 8'd0,   3'd0, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'd56,  0, 1,  0,  0, 8'd0,   3'd0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 8'd0,   0, 1,  0,  0, 8'd0,   3'd0, 0, 0, 0));

        foreach (vecs[i]) runVector(i, vecs[i]);

        // Three words queued plus a sticky flag, then reset lands mid-cycle.
        runVector(100, mkVec(1, 1, 8'd1, 0, 0, 1, 1, 8'd1, 3'd1, 0, 0, 0));
        runVector(101, mkVec(1, 1, 8'd2, 0, 0, 1, 1, 8'd1, 3'd2, 0, 0, 0));
        runVector(102, mkVec(1, 1, 8'd3, 0, 0, 1, 1, 8'd1, 3'd3, 0, 0, 0));
        runVector(103, mkVec(1, 0, 8'd4, 0, 0, 1, 1, 8'd1, 3'd3, 0, 1, 0));
        applyStimulus(1'b1, 1'b1, 8'd77, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async rst rd_valid", 32'(busIf.rd_valid), 32'd0);
        checkOutput("async rst count", 32'(busIf.count), 32'd0);
        checkOutput("async rst err_nodrv", 32'(busIf.err_nodrv), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held rst count", 32'(busIf.count), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        runVector(104, mkVec(1, 1, 8'd132, 0, 0, 1, 1, 8'd132, 3'd1, 0, 0, 0));

`ifdef BUS_XCHK_EN
        busIf.load     = 1'b1;
        busIf.bus_en   = 1'b1;
        tbBusData      = 'z;
        busIf.rd_ready = 1'b0;
        busIf.clr_err  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("xchk err_x", 32'(busIf.err_x), 32'd1);
        checkOutput("xchk count", 32'(busIf.count), 32'd2);
`endif

        // Randomized traffic against a queue model built from the FIFO rules.
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        pulseReset();
        q.delete();
        mNodrv = 1'b0;
        mOvf   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic ld, en, rdy, clr, rdM, fullM, setNodrv, setOvf;
            logic [7:0] d;
            ld  = ($urandom_range(0, 99) < 60);
            en  = ($urandom_range(0, 99) < 80);
            rdy = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 10);
            d   = 8'($urandom);
            applyStimulus(ld, en, d, rdy, clr);

            fullM    = (q.size() == DEPTH);
            rdM      = (q.size() != 0) && rdy;
            setNodrv = ld && !en;
            setOvf   = ld && en && fullM && !rdM;
            mNodrv   = setNodrv ? 1'b1 : (clr ? 1'b0 : mNodrv);
            mOvf     = setOvf   ? 1'b1 : (clr ? 1'b0 : mOvf);
            if (rdM) void'(q.pop_front());
            if (ld && en && (!fullM || rdM)) q.push_back(int'(d));

            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d count", i), 32'(busIf.count), 32'(q.size()));
            checkOutput($sformatf("rand%0d rd_valid", i), 32'(busIf.rd_valid), 32'(q.size() != 0));
            checkOutput($sformatf("rand%0d full", i), 32'(busIf.full), 32'(q.size() == DEPTH));
            if (q.size() != 0)
                checkOutput($sformatf("rand%0d rd_data", i), 32'(busIf.rd_data), 32'(q[0]));
            checkOutput($sformatf("rand%0d err_nodrv", i), 32'(busIf.err_nodrv), 32'(mNodrv));
            checkOutput($sformatf("rand%0d err_ovf", i), 32'(busIf.err_ovf), 32'(mOvf));
            checkOutput($sformatf("rand%0d err_x", i), 32'(busIf.err_x), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
